// File: rtl/urng_pair.sv
// urng_pair: two warmed-up xorshift64 generators feeding a (U1,U2) pair of doubles in (0,1)
// to the Box-Muller datapath, two-edge request latency, one pair per cycle.
module urng_pair #(
   parameter int WARMUP = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        seed_ld,
   input  logic [63:0] seed,
   input  logic        req,
   output logic        ready,
   output logic        pushout,
   output logic [63:0] U1,
   output logic [63:0] U2
);
   localparam logic [63:0] GOLD = 64'h9E3779B97F4A7C15;
   localparam logic [63:0] MIX  = 64'hD1B54A32D192ED03;
   typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;
   state_t      state, state_n;
   logic [7:0]  cnt;
   logic [63:0] s1, s2, mix;
   logic        v_a, warm_step, step_en;
   function automatic logic [63:0] xs(input logic [63:0] x);
      logic [63:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 7);
      return y ^ (y << 17);
   endfunction
   // f*2^-52 is exact in a double: normalise on the leading one, no rounding needed
   function automatic logic [63:0] conv(input logic [51:0] f);
      logic [5:0] lz;
      lz = 6'd0;
      for (int i = 0; i < 52; i++)
         if (f[i]) lz = 6'(51 - i);
      return f == 52'd0 ? 64'h3CA0_0000_0000_0000
                        : {1'b0, 11'd1022 - {5'd0, lz}, f << (lz + 6'd1)};
   endfunction
   assign mix       = seed ^ MIX;
   assign ready     = state == RUN;
   assign warm_step = state == WARM && cnt != 8'(WARMUP);
   assign step_en   = !seed_ld && (warm_step || (ready && req));
   always_comb begin
      state_n = state;
      if (seed_ld) state_n = WARM;
      else if (state == WARM && !warm_step) state_n = RUN;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         s1      <= '0;
         s2      <= '0;
         cnt     <= '0;
         v_a     <= 1'b0;
         pushout <= 1'b0;
         U1      <= '0;
         U2      <= '0;
      end else begin
         state   <= state_n;
         v_a     <= !seed_ld && ready && req;
         pushout <= !seed_ld && v_a;
         if (seed_ld) begin
            s1  <= seed == 64'd0 ? GOLD : seed;
            s2  <= mix == 64'd0 ? GOLD : mix;
            cnt <= '0;
         end else begin
            if (step_en) begin
               s1 <= xs(s1);
               s2 <= xs(s2);
            end
            if (warm_step) cnt <= cnt + 8'd1;
            if (v_a) begin
               U1 <= conv(s1[63:12]);
               U2 <= conv(s2[63:12]);
            end
         end
      end
   end
endmodule

// File: doc/urng_pair.md
# urng_pair

Uniform random source for the Box-Muller datapath. Produces, per request, a pair of IEEE-754 double-precision values `U1` and `U2`, each strictly inside (0,1), with a `pushout` strobe. Its outputs connect directly to the `U1`, `U2` and `pushin` inputs of the Box-Muller top. Two independent xorshift64 generators are seeded from one 64-bit seed and are warmed up before they issue any output.

## Interface
- `WARMUP`, default 16: number of discarded generator steps after each seed load (0..255).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `seed_ld` in 1: one-cycle load strobe for `seed`.
- `seed` in 64: seed value, sampled when `seed_ld` = 1.
- `req` in 1: request one (U1,U2) pair; honoured only in RUN.
- `ready` out 1: high while the FSM is in RUN.
- `pushout` out 1: `U1` and `U2` are valid this cycle.
- `U1` out 64: uniform double in (0,1), from generator 1.
- `U2` out 64: uniform double in (0,1), from generator 2.

## Operation
- **Generator step** (xorshift64, applied to s1 and s2 in parallel):
  - x ^= x<<13
  - x ^= x>>7
  - x ^= x<<17
- **Seeding:**
  - s1 = seed, or 64'h9E3779B97F4A7C15 if seed == 0.
  - s2 = seed ^ 64'hD1B54A32D192ED03, or 64'h9E3779B97F4A7C15 if that XOR is 0.
- **Conversion** of a stepped state r:
  - f = r[63:12] (52 bits); value = f·2^-52.
  - lz = leading-zero count of f (0..51).
  - sign = 0; exponent = 1022 − lz; mantissa = (f << (lz+1))[51:0].
  - Conversion is exact; no rounding.
  - f == 0 emits 64'h3CA0_0000_0000_0000 (2^-53), so the output is never 0 and never 1.
- **FSM states:**
  - IDLE: after reset. `ready` = 0, no stepping, no output.
  - WARM: entered on `seed_ld`. Steps both generators once per cycle, `WARMUP` times, using an 8-bit counter. Outputs suppressed. Goes to RUN when the counter reaches `WARMUP`; with `WARMUP` = 0 it goes straight to RUN on the next edge.
  - RUN: `ready` = 1. Each cycle with `req` = 1, both generators step once and the stepped values enter the pipeline. `req` = 0 holds the states.
- **Precedence:**
  - `seed_ld` from any state reloads the seeds, clears the warm counter, enters WARM and flushes the valid pipeline. In-flight pairs are dropped, so `pushout` = 0 from the next cycle.
  - `seed_ld` overrides `req` in the same cycle.
  - `req` outside RUN is ignored; nothing is queued.
- **Pipeline** (no backpressure; downstream always accepts):
  - Stage A: register the stepped s1/s2 and `v_a` = `req` & RUN.
  - Stage B: register the converted `U1`/`U2` and `pushout` = `v_a`.

## Timing
- **Reset values:**
  - FSM = IDLE; s1 = s2 = 0; warm counter = 0; `v_a` = 0.
  - `U1` = `U2` = 64'h0; `pushout` = 0; `ready` = 0.
  - Reset mid-operation aborts immediately; nothing in flight survives.
- **Seed to ready:**
  - `seed_ld` at edge k: WARM from k.
  - `ready` rises after edge k + `WARMUP` + 1.
- **Request to output:**
  - `req` sampled at edge n (in RUN): `pushout` = 1 and data valid after edge n+1.
  - Latency is 2 edges; throughput is 1 pair per cycle.
- **Between pulses:** `U1`/`U2` hold their last value while `pushout` = 0. `pushout` is a one-cycle strobe per accepted `req`.
- **Sequence invariance:** back-to-back and gapped `req` give the same value sequence; gaps do not advance the generators.

## Test plan
- **Reset:** assert `rst` mid-stream, with `req` held at 1 → `pushout` = 0, `U1` = `U2` = 0, `ready` = 0 asynchronously. No `pushout` after release until a reseed and a `req`.
- **First-value check** (`WARMUP` = 0, seed = 1, one `req` in RUN) → s1 steps to 64'h0000_0000_4082_2041, and 2 edges later `U1` = 64'h3DD0_2088_0000_0000 with `pushout` = 1. `U2` matches the C model of s2 = 1 ^ 64'hD1B54A32D192ED03.
- **Zero seed** (`WARMUP` = 16, seed = 0) → `ready` rises 17 edges after `seed_ld`. The first pair equals the model seeded with 64'h9E3779B97F4A7C15.
- **Streaming:** hold `req` = 1 for 1000 cycles, then repeat with random `req` gaps → every `pushout` pair matches the model in order. Exponents are ≤ 0x3FE and no output is 0 or ≥ 1.0.
- **Reseed during traffic:** `seed_ld` while `req` = 1 with 2 pairs in flight → those pairs are not emitted, `ready` drops, and the sequence after warmup equals a fresh run from the same seed.
- **Ignored requests:** `req` in IDLE or WARM → no `pushout`, and the generator states are unchanged (checked against the model after entering RUN).
